// File: rtl/riscv_pkg.sv
// Shared RISC-V store-path definitions: funct3 store widths, serializer state encoding
// and a helper mapping store width to the index of its final byte.
package riscv_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    function automatic logic [2:0] lastBeatIdx(input logic [1:0] size);
        logic [2:0] last;
        case ({1'b0, size})
            F3_SB:   last = 3'd0;
            F3_SH:   last = 3'd1;
            F3_SW:   last = 3'd3;
            F3_SD:   last = 3'd7;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/store_byte_serializer.sv
// Narrows a 64-bit store value to SB/SH/SW/SD width and writes it little-endian,
// one byte per req/ack beat, to a byte-wide data-memory port.
module store_byte_serializer
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic              errFlag_q, errFlag_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            waitCnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
            errFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            waitCnt_q <= waitCnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            size_q    <= size_d;
            errFlag_q <= errFlag_d;
        end
    end

    // The wait counter measures how long the current beat has been presented;
    // reaching TIMEOUT without an ack abandons the rest of the store.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        waitCnt_d = waitCnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        size_d    = size_q;
        errFlag_d = errFlag_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (funct3[2]) begin
                        errFlag_d = 1'b1;
                        state_d   = ST_FIN;
                    end else begin
                        state_d   = ST_REQ;
                        idx_d     = '0;
                        waitCnt_d = '0;
                        addr_d    = addr;
                        data_d    = wdata;
                        size_d    = funct3[1:0];
                        errFlag_d = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    waitCnt_d = '0;
                    if (idx_q == lastBeatIdx(size_q)) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
                    waitCnt_d = CNT_W'(TIMEOUT);
                    errFlag_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            ST_FIN: begin
                state_d   = ST_IDLE;
                waitCnt_d = '0;
                errFlag_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req   = (state_q == ST_REQ);
    assign busy      = (state_q == ST_REQ);
    assign done      = (state_q == ST_FIN);
    assign err       = (state_q == ST_FIN) && errFlag_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q[{idx_q, 3'b000} +: 8];

endmodule
